// File: rtl/audio_output_arbiter.sv
// ---------------------------------------------------------------------------
// audio_output_arbiter
//
// Purpose:
//   Shares the single speaker path (volume_control -> pwm/pdm) between up to
//   NUM_SRC audio requesters. Ownership is decided on 12 kHz sample strobes by
//   a round-robin scan starting after the last owner. An owner is protected
//   from preemption for MIN_HOLD strobes, and every ownership change inserts
//   GAP_SAMPLES zero-valued samples so the hand-over does not click.
//
// Optional build macro:
//   ARB_FADE_EN - each new owner fades in over 8 samples (arithmetic shift
//                 right by 7, 6, ... 0). Undefined: full scale immediately.
//
// Ports:
//   clk_in           system clock (clk_m)
//   rst_in           asynchronous, active-low reset
//   sample_valid_in  single-cycle sample strobe; all decisions happen on it
//   req_in           level request per source
//   audio_in         packed signed samples, source i at [i*SAMPLE_W +: SAMPLE_W]
//   grant_out        one-hot current owner, or zero
//   audio_out        signed sample to volume_control (1 clk after the strobe)
//   audio_valid_out  single-cycle pulse whenever audio_out is updated
//   busy_out         high while a source owns the path or a gap is running
// ---------------------------------------------------------------------------
module audio_output_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int SAMPLE_W    = 8,
    parameter int MIN_HOLD    = 1200,
    parameter int GAP_SAMPLES = 12
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        sample_valid_in,
    input  logic [NUM_SRC-1:0]          req_in,
    input  logic [NUM_SRC*SAMPLE_W-1:0] audio_in,
    output logic [NUM_SRC-1:0]          grant_out,
    output logic [SAMPLE_W-1:0]         audio_out,
    output logic                        audio_valid_out,
    output logic                        busy_out
);
    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int GAP_W  = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                valid_q, valid_d;
`ifdef ARB_FADE_EN
    logic [2:0]          fade_step_q, fade_step_d;
`endif

    // Unpack the flat sample bus into one signed word per source.
    logic signed [SAMPLE_W-1:0] src_sample [NUM_SRC];
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_sample[gi] = audio_in[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    // Round-robin winner: rotate the request vector so bit 0 is the source
    // right after the last owner, then take the lowest set bit. The last owner
    // itself lands in the top bit, so it only wins when nobody else asks.
    logic [NUM_SRC-1:0] req_rot;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    always_comb begin
        req_rot   = NUM_SRC'({req_in, req_in} >> (int'(last_owner_q) + 1));
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(last_owner_q) + 1 + i) % NUM_SRC);
            end
        end
    end

    // While in OWN, grant_q is the one-hot of the owner.
    logic owner_req;
    logic other_req;
    assign owner_req = |(req_in & grant_q);
    assign other_req = |(req_in & ~grant_q);

    logic [HOLD_W-1:0]          hold_inc;
    logic [GAP_W-1:0]           gap_inc;
    logic signed [SAMPLE_W-1:0] owner_level;
    logic signed [SAMPLE_W-1:0] win_level;
    logic                       grant_winner;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_d      = grant_q;
        audio_d      = audio_q;
        valid_d      = 1'b0;
        grant_winner = 1'b0;
        hold_inc     = (hold_cnt_q == HOLD_W'(MIN_HOLD)) ? hold_cnt_q : hold_cnt_q + 1'b1;
        gap_inc      = gap_cnt_q + 1'b1;
`ifdef ARB_FADE_EN
        fade_step_d  = fade_step_q;
        owner_level  = src_sample[last_owner_q] >>> (3'd7 - fade_step_q);
        win_level    = src_sample[win_idx] >>> 3'd7;
`else
        owner_level  = src_sample[last_owner_q];
        win_level    = src_sample[win_idx];
`endif

        if (sample_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_winner = 1'b1;
                    end
                end
                OWN: begin
                    valid_d = 1'b1;
                    if (!owner_req && !other_req) begin
                        state_d = IDLE;
                        grant_d = '0;
                        audio_d = '0;
                    end else if (!owner_req || (hold_inc == HOLD_W'(MIN_HOLD) && other_req)) begin
                        if (GAP_SAMPLES == 0) begin
                            grant_winner = 1'b1;
                        end else begin
                            // The transition strobe is the first zero sample.
                            state_d   = GAP;
                            gap_cnt_d = '0;
                            grant_d   = '0;
                            audio_d   = '0;
                        end
                    end else begin
                        audio_d    = owner_level;
                        hold_cnt_d = hold_inc;
`ifdef ARB_FADE_EN
                        if (fade_step_q != 3'd7) begin
                            fade_step_d = fade_step_q + 3'd1;
                        end
`endif
                    end
                end
                GAP: begin
                    valid_d = 1'b1;
                    audio_d = '0;
                    if (gap_inc >= GAP_W'(GAP_SAMPLES)) begin
                        if (win_found) begin
                            grant_winner = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    audio_d = '0;
                end
            endcase

            // A new grant outputs the winner's first sample on the same strobe.
            if (grant_winner) begin
                state_d      = OWN;
                last_owner_d = win_idx;
                grant_d      = NUM_SRC'(1) << win_idx;
                hold_cnt_d   = '0;
                audio_d      = win_level;
                valid_d      = 1'b1;
`ifdef ARB_FADE_EN
                fade_step_d  = 3'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            last_owner_q <= IDX_W'(NUM_SRC - 1);
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            grant_q      <= '0;
            audio_q      <= '0;
            valid_q      <= 1'b0;
`ifdef ARB_FADE_EN
            fade_step_q  <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            grant_q      <= grant_d;
            audio_q      <= audio_d;
            valid_q      <= valid_d;
`ifdef ARB_FADE_EN
            fade_step_q  <= fade_step_d;
`endif
        end
    end

    assign grant_out       = grant_q;
    assign audio_out       = audio_q;
    assign audio_valid_out = valid_q;
    assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_audio_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_audio_output_arbiter
//
// Three arbiters share the same stimulus:
//   inst0: MIN_HOLD=1200, GAP_SAMPLES=12 (defaults)
//   inst1: MIN_HOLD=4,    GAP_SAMPLES=0
//   inst2: MIN_HOLD=3,    GAP_SAMPLES=2
// A per-instance behavioural model tracks owner, samples held and zero
// samples still owed, and predicts every output after each strobe.
// ---------------------------------------------------------------------------
module tb_audio_output_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NI = 3;
    localparam int M_IDLE = 0;
    localparam int M_OWN  = 1;
    localparam int M_GAP  = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         sv    = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N*W-1:0] audio = '0;

    logic [N-1:0] g  [NI];
    logic [W-1:0] ao [NI];
    logic         av [NI];
    logic         bz [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        audio_output_arbiter #(
            .NUM_SRC    (N),
            .SAMPLE_W   (W),
            .MIN_HOLD   (gi == 0 ? 1200 : (gi == 1 ? 4 : 3)),
            .GAP_SAMPLES(gi == 0 ? 12 : (gi == 1 ? 0 : 2))
        ) u_dut (
            .clk_in         (clk),
            .rst_in         (rst_n),
            .sample_valid_in(sv),
            .req_in         (req),
            .audio_in       (audio),
            .grant_out      (g[gi]),
            .audio_out      (ao[gi]),
            .audio_valid_out(av[gi]),
            .busy_out       (bz[gi])
        );
    end

    // ---------------- behavioural reference model ----------------
    int                  mode  [NI];
    int                  last  [NI];
    int                  held  [NI];   // samples output by the current owner
    int                  zleft [NI];   // zero samples still owed in the gap
    logic [N-1:0]        e_g   [NI];
    logic signed [W-1:0] e_ao  [NI];
    logic                e_av  [NI];
    logic                e_bz  [NI];

    function automatic int hold_of(int m);
        return (m == 0) ? 1200 : ((m == 1) ? 4 : 3);
    endfunction

    function automatic int gap_of(int m);
        return (m == 0) ? 12 : ((m == 1) ? 0 : 2);
    endfunction

    function automatic logic signed [W-1:0] smp(logic [N*W-1:0] a, int k);
        return a[k*W +: W];
    endfunction

    // prior = samples this owner has already produced
    function automatic logic signed [W-1:0] scaled(logic signed [W-1:0] s, int prior);
`ifdef ARB_FADE_EN
        int sh;
        sh = 7 - ((prior > 7) ? 7 : prior);
        return s >>> sh;
`else
        if (prior < 0) return '0;
        return s;
`endif
    endfunction

    function automatic int rr_pick(int lst, logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (((r >> ((lst + i) % N)) & N'(1)) != '0) return (lst + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NI; m++) begin
            mode[m] = M_IDLE; last[m] = N - 1; held[m] = 0; zleft[m] = 0;
            e_g[m] = '0; e_ao[m] = '0; e_av[m] = 1'b0; e_bz[m] = 1'b0;
        end
    endtask

    task automatic take(int m, int w, logic [N*W-1:0] a);
        mode[m] = M_OWN;
        last[m] = w;
        held[m] = 1;
        e_g[m]  = N'(1) << w;
        e_ao[m] = scaled(smp(a, w), 0);
    endtask

    task automatic model_step(int m, logic [N-1:0] r, logic [N*W-1:0] a);
        int w;
        logic mine;
        logic [N-1:0] others;
        w      = rr_pick(last[m], r);
        mine   = ((r >> last[m]) & N'(1)) != '0;
        others = r & ~(N'(1) << last[m]);
        e_av[m] = 1'b1;
        if (mode[m] == M_IDLE) begin
            if (r != '0) take(m, w, a);
            else e_av[m] = 1'b0;
        end else if (mode[m] == M_OWN) begin
            if (!mine && others == '0) begin
                mode[m] = M_IDLE; e_g[m] = '0; e_ao[m] = '0;
            end else if (!mine || (held[m] >= hold_of(m) && others != '0)) begin
                if (gap_of(m) == 0) take(m, w, a);
                else begin
                    mode[m] = M_GAP; zleft[m] = gap_of(m) - 1; e_g[m] = '0; e_ao[m] = '0;
                end
            end else begin
                e_ao[m] = scaled(smp(a, last[m]), held[m]);
                held[m]++;
            end
        end else begin
            e_ao[m] = '0;
            if (zleft[m] > 0) zleft[m]--;
            else if (r != '0) take(m, w, a);
            else mode[m] = M_IDLE;
        end
        e_bz[m] = (mode[m] != M_IDLE);
    endtask

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic strobe(logic [N-1:0] r, logic [N*W-1:0] a);
        @(negedge clk);
        req = r; audio = a; sv = 1'b1;
        @(posedge clk);
        for (int m = 0; m < NI; m++) model_step(m, r, a);
        #1;
        sv = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < NI; m++) e_av[m] = 1'b0;
        end
    endtask

    task automatic go_idle();
        for (int i = 0; i < 16; i++) strobe('0, audio);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        for (int m = 0; m < NI; m++) begin
            n_checks++;
            if ({g[m], ao[m], av[m], bz[m]} !== '0)
                $display("FAIL reset inst%0d: got g=%b ao=%0d v=%b b=%b want all zero",
                         m, g[m], $signed(ao[m]), av[m], bz[m]);
            else n_pass++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_own();
        logic [N*W-1:0] a;
        a = '0;
        a[0 +: W] = 8'sd100;
        for (int s = 0; s < 5; s++) begin
            strobe(4'b0001, a);
            for (int m = 0; m < NI; m++) begin
                n_checks++;
                if ({g[m], ao[m], av[m], bz[m]} !== {e_g[m], e_ao[m], e_av[m], e_bz[m]})
                    $display("FAIL mid_own inst%0d s%0d: got g=%b ao=%0d v=%b want g=%b ao=%0d v=%b",
                             m, s, g[m], $signed(ao[m]), av[m], e_g[m], e_ao[m], e_av[m]);
                else n_pass++;
            end
            idle(1);
        end
        // Reset in the middle of a clock period, away from any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < NI; m++) begin
            n_checks++;
            if ({g[m], ao[m], av[m], bz[m]} !== '0)
                $display("FAIL async_reset inst%0d: got g=%b ao=%0d b=%b want zero",
                         m, g[m], $signed(ao[m]), bz[m]);
            else n_pass++;
        end
        #1;
        rst_n = 1'b1;
        strobe(4'b0001, a);
        n_checks++;
        if (g[0] !== 4'b0001 || ao[0] !== scaled(8'sd100, 0) || av[0] !== 1'b1 || bz[0] !== 1'b1)
            $display("FAIL regrant inst0: got g=%b ao=%0d v=%b want g=0001 ao=%0d v=1",
                     g[0], $signed(ao[0]), av[0], scaled(8'sd100, 0));
        else n_pass++;
        $display("test_reset_mid_own done");
    endtask

    task automatic test_single();
        logic [N*W-1:0] a;
        go_idle();
        a = '0;
        a[2*W +: W] = -8'sd37;
        strobe(4'b0100, a);
        n_checks++;
        if (g[0] !== 4'b0100 || ao[0] !== scaled(-8'sd37, 0) || av[0] !== 1'b1)
            $display("FAIL single_first: got g=%b ao=%0d v=%b want g=0100 ao=%0d v=1",
                     g[0], $signed(ao[0]), av[0], scaled(-8'sd37, 0));
        else n_pass++;
        idle(1);
        n_checks++;
        if (av[0] !== 1'b0 || ao[0] !== scaled(-8'sd37, 0))
            $display("FAIL single_between: got v=%b ao=%0d want v=0 ao=%0d",
                     av[0], $signed(ao[0]), scaled(-8'sd37, 0));
        else n_pass++;
        strobe(4'b0100, a);
        n_checks++;
        if (av[0] !== 1'b1 || ao[0] !== scaled(-8'sd37, 1) || g[0] !== 4'b0100)
            $display("FAIL single_second: got g=%b ao=%0d v=%b want g=0100 ao=%0d v=1",
                     g[0], $signed(ao[0]), av[0], scaled(-8'sd37, 1));
        else n_pass++;
        $display("test_single done");
    endtask

    task automatic test_release_waiter();
        logic [N*W-1:0] a;
        go_idle();
        a = '0;
        a[1*W +: W] = 8'sd5;
        a[3*W +: W] = -8'sd9;
        strobe(4'b0010, a);
        for (int i = 0; i < 3; i++) strobe(4'b1010, a);
        n_checks++;
        if (g[0] !== 4'b0010)
            $display("FAIL release_owner: got g=%b want 0010", g[0]);
        else n_pass++;
        for (int s = 0; s <= 12; s++) begin
            strobe(4'b1000, a);
            n_checks++;
            if (s < 12) begin
                if (g[0] !== 4'b0000 || ao[0] !== '0 || av[0] !== 1'b1 || bz[0] !== 1'b1)
                    $display("FAIL gap_zero s%0d: got g=%b ao=%0d v=%b b=%b want g=0000 ao=0 v=1 b=1",
                             s, g[0], $signed(ao[0]), av[0], bz[0]);
                else n_pass++;
            end else begin
                if (g[0] !== 4'b1000 || ao[0] !== scaled(-8'sd9, 0))
                    $display("FAIL gap_handover: got g=%b ao=%0d want g=1000 ao=%0d",
                             g[0], $signed(ao[0]), scaled(-8'sd9, 0));
                else n_pass++;
            end
            for (int m = 0; m < NI; m++) begin
                n_checks++;
                if ({g[m], ao[m], av[m], bz[m]} !== {e_g[m], e_ao[m], e_av[m], e_bz[m]})
                    $display("FAIL release_model inst%0d s%0d: got g=%b ao=%0d want g=%b ao=%0d",
                             m, s, g[m], $signed(ao[m]), e_g[m], e_ao[m]);
                else n_pass++;
            end
        end
        $display("test_release_waiter done");
    endtask

    task automatic test_hold();
        logic [N*W-1:0] a;
        logic [N-1:0] r;
        go_idle();
        a = '0;
        a[0*W +: W] = 8'sd11;
        a[2*W +: W] = 8'sd22;
        for (int s = 0; s < 1214; s++) begin
            r = (s >= 10) ? 4'b0101 : 4'b0001;
            strobe(r, a);
            n_checks++;
            if (s < 1200) begin
                if (g[0] !== 4'b0001)
                    $display("FAIL hold_keep s%0d: got g=%b want 0001", s, g[0]);
                else n_pass++;
            end else if (s < 1212) begin
                if (g[0] !== 4'b0000 || ao[0] !== '0)
                    $display("FAIL hold_gap s%0d: got g=%b ao=%0d want g=0000 ao=0",
                             s, g[0], $signed(ao[0]));
                else n_pass++;
            end else begin
                if (g[0] !== 4'b0100 || ao[0] !== scaled(8'sd22, s - 1212))
                    $display("FAIL hold_next s%0d: got g=%b ao=%0d want g=0100 ao=%0d",
                             s, g[0], $signed(ao[0]), scaled(8'sd22, s - 1212));
                else n_pass++;
            end
            for (int m = 0; m < NI; m++) begin
                n_checks++;
                if ({g[m], ao[m], av[m], bz[m]} !== {e_g[m], e_ao[m], e_av[m], e_bz[m]})
                    $display("FAIL hold_model inst%0d s%0d: got g=%b ao=%0d want g=%b ao=%0d",
                             m, s, g[m], $signed(ao[m]), e_g[m], e_ao[m]);
                else n_pass++;
            end
        end
        $display("test_hold done");
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] a;
        int own;
        do_reset();
        a = {$urandom, $urandom};
        for (int s = 0; s < 20; s++) begin
            strobe(4'b1111, a);
            own = (s / 4) % 4;
            n_checks++;
            if (g[1] !== (N'(1) << own) || ao[1] !== scaled(smp(a, own), s % 4))
                $display("FAIL round_robin s%0d: got g=%b ao=%0d want g=%b ao=%0d",
                         s, g[1], $signed(ao[1]), N'(1) << own, scaled(smp(a, own), s % 4));
            else n_pass++;
        end
        $display("test_round_robin done");
    endtask

`ifdef ARB_FADE_EN
    task automatic test_fade();
        logic [N*W-1:0] a;
        int ramp [10] = '{0, 1, 3, 7, 15, 31, 63, 127, 127, 127};
        do_reset();
        a = '0;
        a[0 +: W] = 8'sd127;
        for (int s = 0; s < 10; s++) begin
            strobe(4'b0001, a);
            n_checks++;
            if ($signed(ao[0]) != ramp[s])
                $display("FAIL fade s%0d: got ao=%0d want %0d", s, $signed(ao[0]), ramp[s]);
            else n_pass++;
        end
        $display("test_fade done");
    endtask
`endif

    task automatic test_back_to_back_random();
        logic [N-1:0] r;
        logic [N*W-1:0] a;
        r = '0;
        for (int it = 0; it < 1500; it++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            a = {$urandom, $urandom};
            strobe(r, a);
            for (int m = 0; m < NI; m++) begin
                n_checks++;
                if ({g[m], ao[m], av[m], bz[m]} !== {e_g[m], e_ao[m], e_av[m], e_bz[m]})
                    $display("FAIL random inst%0d it%0d: got g=%b ao=%0d v=%b b=%b want g=%b ao=%0d v=%b b=%b",
                             m, it, g[m], $signed(ao[m]), av[m], bz[m], e_g[m], e_ao[m], e_av[m], e_bz[m]);
                else n_pass++;
            end
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
            end
            for (int m = 0; m < NI; m++) begin
                n_checks++;
                if ({g[m], ao[m], av[m], bz[m]} !== {e_g[m], e_ao[m], e_av[m], e_bz[m]})
                    $display("FAIL random_hold inst%0d it%0d: got g=%b ao=%0d v=%b want g=%b ao=%0d v=%b",
                             m, it, g[m], $signed(ao[m]), av[m], e_g[m], e_ao[m], e_av[m]);
                else n_pass++;
            end
        end
        $display("test_back_to_back_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_own();
        test_single();
        test_release_waiter();
        test_hold();
        test_round_robin();
`ifdef ARB_FADE_EN
        test_fade();
`endif
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_output_arbiter.md
Name: audio_output_arbiter

Overview:
Shares the single speaker output path (volume_control -> pwm/pdm) between up to NUM_SRC audio requesters: tone generators, mic passthrough and recorder playback. It replaces static switch-priority selection with a sample-aligned, round-robin, hold-time-protected arbiter. On every ownership change it inserts a muted gap so switches do not click. It sits between the 12 kHz audio sources and volume_control, and runs on clk_m.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
SAMPLE_W, 8, signed sample width
MIN_HOLD, 1200, strobes an owner keeps its grant before it can be preempted (100 ms at 12 kHz); must be >= 1
GAP_SAMPLES, 12, zero-valued strobes inserted between owners; 0 disables the gap

Ports:
clk_in  input  1  system clock (clk_m, 98.3 MHz)
rst_in  input  1  asynchronous, active-low reset
sample_valid_in  input  1  single-cycle 12 kHz sample strobe
req_in  input  NUM_SRC  level request per source
audio_in  input  NUM_SRC*SAMPLE_W  packed signed samples; source i occupies bits [i*SAMPLE_W +: SAMPLE_W]
grant_out  output  NUM_SRC  one-hot current owner, or all zero
audio_out  output  SAMPLE_W  signed sample to volume_control
audio_valid_out  output  1  single-cycle pulse when audio_out updates
busy_out  output  1  high in OWN or GAP

Behaviour:
- Reset (rst_in low, asynchronous):
  - Outputs: grant_out=0, audio_out=0, audio_valid_out=0, busy_out=0.
  - Internal: state=IDLE, last_owner=NUM_SRC-1, hold_cnt=0, gap_cnt=0.
  - A reset asserted mid-operation aborts immediately, with no fade or gap.
- Evaluation timing:
  - All arbitration and state changes are evaluated only on cycles with sample_valid_in=1.
  - Between strobes, every output and register holds its value.
  - audio_out and audio_valid_out register one cycle after the strobe. Latency is 1 clk.
  - audio_valid_out pulses on every strobe in every state except IDLE. In IDLE, audio_out=0 and there is no pulse.
- Winner selection: round-robin. Scan indices last_owner+1, +2, … modulo NUM_SRC and take the first with req set. last_owner updates on each new grant.
- State IDLE:
  - On a strobe with any req set, pick the winner, set grant_out, set hold_cnt=0, go to OWN.
  - The first OWN sample is output on that same strobe. There is no gap leaving IDLE.
- State OWN (owner k):
  - On each strobe: audio_out <= audio_in[k], and hold_cnt increments, saturating at MIN_HOLD.
  - If req_in[k]=0 and no other req is set: go to IDLE, grant_out=0, audio_out=0.
  - If req_in[k]=0 and another req is set: go to GAP.
  - If req_in[k]=1, hold_cnt==MIN_HOLD and another req is set: preempt, go to GAP.
  - Otherwise stay in OWN.
  - On a transition strobe, audio_out <= 0.
- State GAP:
  - grant_out=0, audio_out <= 0 on each strobe, gap_cnt counts strobes.
  - When gap_cnt reaches GAP_SAMPLES, re-evaluate requests on that strobe:
    - any req set: grant the winner, go to OWN, output its sample;
    - no req set: go to IDLE.
  - With GAP_SAMPLES=0, GAP is skipped and the winner is granted on the transition strobe itself.
- A new owner cannot be the previous owner unless it is the only requester. That follows from the round-robin order.
- A req pulse shorter than one strobe period is ignored unless it is sampled on a strobe.
- Sample selection is a plain mux; audio_out is never scaled (except under ARB_FADE_EN).
- grant_out is always one-hot or zero.

Optional Feature:
ARB_FADE_EN
- Defined:
  - A 3-bit fade_step register is cleared on every new grant, including from IDLE.
  - In OWN, audio_out = audio_in[k] >>> (7 - fade_step), an arithmetic shift.
  - fade_step increments each strobe, saturating at 7, so full scale is reached on the 8th sample.
  - hold_cnt and arbitration are unaffected.
- Undefined: the granted sample passes at full scale from the first strobe; no fade_step register exists.

Test Plan:
- Reset mid-OWN: req_in=4'b0001 with audio_in[0]=8'sd100 for 5 strobes, then rst_in low mid-period -> grant_out=0 and audio_out=0 asynchronously; after release, the next strobe re-grants src0 with no gap.
- Single requester: req_in=4'b0100, audio_in[2]=-8'sd37 -> grant_out=4'b0100 and audio_out=-37 one clk after the first strobe; audio_valid_out pulses once per strobe.
- Release with waiter (GAP_SAMPLES=12): src1 owns, src3 requesting, src1 drops req -> exactly 12 zero samples with grant_out=0, then grant_out=4'b1000 with src3 samples.
- Hold protection (MIN_HOLD=1200): src0 owns and src2 requests at strobe 10 -> src0 keeps the grant through strobe 1199; preemption happens on strobe 1200, followed by the gap, then src2.
- Round-robin fairness: all four requesting continuously, MIN_HOLD=4, GAP_SAMPLES=0 -> grant order 0,1,2,3,0 with each owner holding for 4 strobes.
- ARB_FADE_EN defined, audio_in[0]=8'sd127 constant -> first 8 outputs 0,1,3,7,15,31,63,127, then 127 steady.
